// File: rtl/mips_pkg.sv
// Shared register-file constants and types for the MIPS datapath.
// Used by mips_regfile and rf_read_port.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: index select, $0 zero-force and,
// when RF_BYPASS_EN is defined, a write-first bypass from the write port.
module rf_read_port
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0]                rd_addr_i,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs_i,
    input  logic                             rst_ni,
    input  logic                             wr_en_i,
    input  logic [ADDR_W-1:0]                wr_addr_i,
    input  logic [DATA_W-1:0]                wr_data_i,
    output logic [DATA_W-1:0]                rd_data_o
);

    logic addr_is_zero;
    logic [DATA_W-1:0] stored_data;

    assign addr_is_zero = (rd_addr_i == ADDR_W'(ZERO_REG));
    assign stored_data  = regs_i[rd_addr_i];

`ifdef RF_BYPASS_EN
    logic bypass_hit;

    // Only a write that will actually commit on this edge may be forwarded.
    assign bypass_hit = rst_ni && wr_en_i && !addr_is_zero && (wr_addr_i == rd_addr_i);

    always_comb begin
        rd_data_o = stored_data;
        if (addr_is_zero) begin
            rd_data_o = '0;
        end else if (bypass_hit) begin
            rd_data_o = wr_data_i;
        end
    end
`else
    logic unused_bypass_inputs;

    assign unused_bypass_inputs = ^{rst_ni, wr_en_i, wr_addr_i, wr_data_i};

    always_comb begin
        rd_data_o = stored_data;
        if (addr_is_zero) begin
            rd_data_o = '0;
        end
    end
`endif

endmodule

// File: rtl/mips_regfile.sv
// MIPS 32-entry register file: two read ports, one write port, debug read, write counter.
// Optional write-first read bypass selected by the RF_BYPASS_EN macro.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int unsigned NumRegs = (ADDR_W == REG_ADDR_W) ? NUM_REGS : (1 << ADDR_W);

    logic [NumRegs-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [CNT_W-1:0]               wr_count_q, wr_count_d;
    logic                           wr_commit;

    // wr_en gates first so X on addr/data while idle never reaches the array.
    assign wr_commit = wr_en && (wr_addr != '0);

    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (wr_commit) begin
            regs_d[wr_addr] = wr_data;
            wr_count_d      = wr_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q     <= '0;
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port1 (
        .rd_addr_i (rd_addr1),
        .regs_i    (regs_q),
        .rst_ni    (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_data_o (rd_data1)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port2 (
        .rd_addr_i (rd_addr2),
        .regs_i    (regs_q),
        .rst_ni    (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_data_o (rd_data2)
    );

    // Debug view always shows committed state.
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: directed scenarios then randomized traffic
// compared against an array-based reference model.
module tb_mips_regfile;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    reg_addr_t   wr_addr;
    logic [31:0] wr_data;
    reg_addr_t   rd_addr1, rd_addr2, dbg_addr;
    logic [31:0] rd_data1, rd_data2, dbg_data;
    logic [31:0] wr_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [NUM_REGS];
    logic [31:0] model_cnt;

`ifdef RF_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    always #5 clk = ~clk;

    mips_regfile dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_count (wr_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Value a read port should show right now, given the current inputs.
    function automatic logic [31:0] exp_read(input reg_addr_t a, input bit bypass_ok);
        if (a == 0) return 32'h0;
        if (bypass_ok && Bypass && rst_n === 1'b1 && wr_en === 1'b1 && wr_addr === a)
            return wr_data;
        return model[a];
    endfunction

    task automatic drive(input logic r, input logic we, input reg_addr_t wa, input logic [31:0] wd,
                         input reg_addr_t a1, input reg_addr_t a2, input reg_addr_t da);
        @(negedge clk);
        rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr1 = a1; rd_addr2 = a2; dbg_addr = da;
        #1;
    endtask

    task automatic check_now(input string tag);
        check({tag, ".rd1"}, rd_data1, exp_read(rd_addr1, 1'b1));
        check({tag, ".rd2"}, rd_data2, exp_read(rd_addr2, 1'b1));
        check({tag, ".dbg"}, dbg_data, exp_read(dbg_addr, 1'b0));
        check({tag, ".cnt"}, wr_count, model_cnt);
    endtask

    // Advance one edge and apply the specified effect of that edge to the model.
    task automatic edge_update();
        logic r, we;
        reg_addr_t wa;
        logic [31:0] wd;
        r = rst_n; we = wr_en; wa = wr_addr; wd = wr_data;
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
            model_cnt = 32'h0;
        end else if (we && wa != 0) begin
            model[wa] = wd;
            model_cnt = model_cnt + 32'd1;
        end
    endtask

    initial begin
        logic [31:0] exp4;
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr1 = '0; rd_addr2 = '0; dbg_addr = '0;
        model_cnt = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;

        // 1: reset beats a coincident write
        drive(1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd8, 5'd8);
        edge_update();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 5'd8);
        check("t1.rd1", rd_data1, 32'h0);
        check("t1.dbg", dbg_data, 32'h0);
        check("t1.cnt", wr_count, 32'h0);

        // 2: writes to $0 vanish and are not counted
        drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        edge_update();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        check("t2.rd1", rd_data1, 32'h0);
        check("t2.cnt", wr_count, 32'h0);

        // 3: both destination-mux extremes
        drive(1'b1, 1'b1, 5'd31, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
        edge_update();
        drive(1'b1, 1'b1, 5'd0, 32'hAAAA_AAAA, 5'd0, 5'd0, 5'd0);
        edge_update();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd31, 5'd0, 5'd31);
        check("t3.rd1", rd_data1, 32'h1234_5678);
        check("t3.rd2", rd_data2, 32'h0);
        check("t3.dbg", dbg_data, 32'h1234_5678);
        check("t3.cnt", wr_count, 32'd1);

        // 4: same-cycle read of the register being written, on both ports
        drive(1'b1, 1'b1, 5'd4, 32'h0000_0004, 5'd0, 5'd0, 5'd0);
        edge_update();
        drive(1'b1, 1'b1, 5'd4, 32'hCAFE_0001, 5'd4, 5'd4, 5'd4);
        exp4 = Bypass ? 32'hCAFE_0001 : 32'h0000_0004;
        check("t4.pre.rd1", rd_data1, exp4);
        check("t4.pre.rd2", rd_data2, exp4);
        check("t4.pre.dbg", dbg_data, 32'h0000_0004);
        edge_update();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 5'd4);
        check("t4.post.rd1", rd_data1, 32'hCAFE_0001);
        check("t4.post.rd2", rd_data2, 32'hCAFE_0001);

        // 5: fill 1..31 with their index from a clean reset, sweep debug port
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        edge_update();
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'b1, reg_addr_t'(i), 32'(i), 5'd0, 5'd0, 5'd0);
            edge_update();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, reg_addr_t'(i), reg_addr_t'(31 - i), reg_addr_t'(i));
            check("t5.dbg", dbg_data, 32'(i));
            check("t5.rd1", rd_data1, 32'(i));
            check("t5.rd2", rd_data2, 32'(31 - i));
        end
        check("t5.cnt", wr_count, 32'd31);

        // 6: mid-stream reset wipes everything, counting restarts
        drive(1'b0, 1'b1, 5'd17, 32'h5555_0000, 5'd0, 5'd0, 5'd0);
        edge_update();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, reg_addr_t'(i), reg_addr_t'(i), reg_addr_t'(i));
            check("t6.rd1", rd_data1, 32'h0);
            check("t6.rd2", rd_data2, 32'h0);
            check("t6.dbg", dbg_data, 32'h0);
        end
        check("t6.cnt0", wr_count, 32'h0);
        drive(1'b1, 1'b1, 5'd9, 32'h9999_0009, 5'd9, 5'd0, 5'd9);
        edge_update();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 5'd9);
        check("t6.cnt1", wr_count, 32'd1);
        check("t6.rd9", rd_data1, 32'h9999_0009);

        // Randomized traffic against the model, including X on idle write inputs
        for (int n = 0; n < 600; n++) begin
            logic r, we;
            reg_addr_t wa, a1, a2, da;
            logic [31:0] wd;
            r  = ($urandom_range(0, 39) != 0);
            we = ($urandom_range(0, 2) != 0);
            wa = reg_addr_t'($urandom_range(0, 31));
            wd = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? wa : reg_addr_t'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : reg_addr_t'($urandom_range(0, 31));
            da = ($urandom_range(0, 3) == 0) ? wa : reg_addr_t'($urandom_range(0, 31));
            drive(r, we, wa, wd, a1, a2, da);
            if (!we && $urandom_range(0, 1) == 1) begin
                wr_addr = 'x;
                wr_data = 'x;
                #1;
            end
            check_now("rand");
            edge_update();
        end
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd3);
        check_now("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
